// File: rtl/nsa_pkg.sv
// Shared constants for the nibble-serial adder: state encoding and slice width.
package nsa_pkg;
  localparam int NIBBLE_W = 4;

  localparam logic [1:0] NSA_IDLE = 2'd0;
  localparam logic [1:0] NSA_RUN  = 2'd1;
  localparam logic [1:0] NSA_DONE = 2'd2;
endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry adder slice, shared across all nibbles of an add.
module add4_slice (
  output logic [3:0] s,
  output logic       cout,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);
  logic [4:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end
endmodule

// File: rtl/nibble_serial_add.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock through a single add4_slice.
// Optional NSA_SUB_EN adds a 'sub' input that turns the operation into a-b.
module nibble_serial_add
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NSA_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  int                    nib_idx;
  logic [NIBBLE_W-1:0]   slice_a, slice_b, slice_s;
  logic                  slice_co;

  assign nib_idx = int'(cnt_q) * NIBBLE_W;
  assign slice_a = a_q[nib_idx +: NIBBLE_W];
  assign slice_b = b_q[nib_idx +: NIBBLE_W];

  add4_slice u_slice (
    .s    (slice_s),
    .cout (slice_co),
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      NSA_IDLE, NSA_DONE: begin
        if (start) begin
          a_d     = a;
          cnt_d   = '0;
          state_d = NSA_RUN;
`ifdef NSA_SUB_EN
          b_d     = sub ? ~b : b;
          carry_d = sub | cin;
`else
          b_d     = b;
          carry_d = cin;
`endif
        end else begin
          state_d = NSA_IDLE;
        end
      end
      NSA_RUN: begin
        sum_d[nib_idx +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        if (cnt_q == LAST) begin
          cout_d  = slice_co;
          // b_q already holds ~b when subtracting, so this covers both ops
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (slice_s[NIBBLE_W-1] != a_q[WIDTH-1]);
          state_d = NSA_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = NSA_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= NSA_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == NSA_RUN);
  assign done     = (state_q == NSA_DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_add.sv
// Scoreboard bench for nibble_serial_add: directed vectors with hand-computed results.
module tb_nibble_serial_add;
  logic        clk, rst, start, cin;
  logic [15:0] a, b;
  logic        busy, done, cout, overflow;
  logic [15:0] sum;
`ifdef NSA_SUB_EN
  logic        sub;
`endif

  typedef struct {
    int          id;
    logic [15:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  nibble_serial_add #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef NSA_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h, want %0h", nm, id, act, want);
    end
  endtask

  // Monitor: every done pulse pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q.size() == 0) begin
          check("unexpected_done", -1, 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sum", e.id, {16'd0, sum}, {16'd0, e.s});
          check("cout", e.id, {31'd0, cout}, {31'd0, e.c});
          check("overflow", e.id, {31'd0, overflow}, {31'd0, e.v});
        end
      end
    end
  end

  task automatic launch(input int id, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb, input bit push,
                        input logic [15:0] es, input logic ec, input logic ev);
    exp_t e;
    a = av; b = bv; cin = ci; start = 1'b1;
`ifdef NSA_SUB_EN
    sub = sb;
`else
    if (sb) $display("note: sub vector %0d issued without NSA_SUB_EN", id);
`endif
    if (push) begin
      e.id = id; e.s = es; e.c = ec; e.v = ev;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
  endtask

  // Called at the negedge following acceptance; returns at the negedge where done is seen.
  task automatic wait_done(input int id, output int k, output int busy_n);
    k = 1; busy_n = 0;
    while (done !== 1'b1 && k < 30) begin
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) check("done_timeout", id, 32'd0, 32'd1);
  endtask

  task automatic run(input int id, input logic [15:0] av, input logic [15:0] bv,
                     input logic ci, input logic sb,
                     input logic [15:0] es, input logic ec, input logic ev);
    int k, bn;
    launch(id, av, bv, ci, sb, 1'b1, es, ec, ev);
    wait_done(id, k, bn);
    @(negedge clk);
  endtask

  initial begin
    int k, bn, t1, t2, dcount;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef NSA_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 0, {31'd0, busy}, 32'd0);
    check("rst_done", 0, {31'd0, done}, 32'd0);
    check("rst_sum", 0, {16'd0, sum}, 32'd0);
    check("rst_cout", 0, {31'd0, cout}, 32'd0);
    check("rst_ovf", 0, {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Vector 1: zero add, check latency and busy length
    launch(1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    wait_done(1, k, bn);
    check("latency", 1, k, 32'd5);
    check("busy_cycles", 1, bn, 32'd4);
    @(negedge clk);

    run(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run(4, 16'h000C, 16'h0008, 1'b1, 1'b0, 16'h0015, 1'b0, 1'b0);
    run(5, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run(6, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Vector 7: start re-pulsed during RUN must be ignored
    launch(7, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, k, bn);
    check("ignored_start_latency", 7, k, 32'd4);
    repeat (3) @(negedge clk);

    // Vectors 8/9: back-to-back start in the DONE cycle
    launch(8, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0);
    wait_done(8, k, bn);
    t1 = cyc;
    launch(9, 16'h0010, 16'h0020, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);
    wait_done(9, k, bn);
    t2 = cyc;
    check("b2b_spacing", 9, t2 - t1, 32'd5);
    @(negedge clk);

    // Vector 10: reset two cycles after acceptance aborts the add
    launch(10, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_sum", 10, {16'd0, sum}, 32'd0);
    check("abort_busy", 10, {31'd0, busy}, 32'd0);
    check("abort_done", 10, {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    check("abort_no_done", 10, dcount, 32'd0);
    run(11, 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

`ifdef NSA_SUB_EN
    run(12, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run(13, 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run(14, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run(15, 16'h0005, 16'h0007, 1'b0, 1'b0, 16'h000C, 1'b0, 1'b0);
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 99, q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, want finish");
    $fatal(1);
  end
endmodule
